// File: rtl/mma_pkg.sv
// Shared widths and packed-half helpers for the matrix multiply-accumulate tile.
package mma_pkg;

  // Widest operand precision the half-extraction helpers handle.
  localparam int MAX_P = 64;

  // Every sum in the tile is carried in four times the operand width.
  function automatic int accw(input int p);
    return 4 * p;
  endfunction

  // Upper signed p/2-bit half of a p-bit element, sign-extended to MAX_P/2 bits.
  function automatic logic signed [MAX_P/2-1:0] hi(input logic [MAX_P-1:0] x, input int p);
    logic [MAX_P/2-1:0] r;
    r = '0;
    for (int b = 0; b < MAX_P / 2; b++) begin
      r[b] = (b < p / 2) ? x[b + p / 2] : x[p - 1];
    end
    return r;
  endfunction

  // Lower signed p/2-bit half of a p-bit element, sign-extended to MAX_P/2 bits.
  function automatic logic signed [MAX_P/2-1:0] lo(input logic [MAX_P-1:0] x, input int p);
    logic [MAX_P/2-1:0] r;
    r = '0;
    for (int b = 0; b < MAX_P / 2; b++) begin
      r[b] = (b < p / 2) ? x[b] : x[p / 2 - 1];
    end
    return r;
  endfunction

endpackage

// File: rtl/mma_dot_product.sv
// One output element: c_in plus the signed dot product of a row of A and a column of B.
module mma_dot_product
  import mma_pkg::*;
#(
  parameter int P            = 8,
  parameter int K            = 2,
  parameter int TREE         = 0,
  parameter int CONFIGURABLE = 0
) (
  input  logic signed [P-1:0]       a_row [K],
  input  logic signed [P-1:0]       b_col [K],
  input  logic signed [4*P-1:0]     c_in,
  input  logic                      halved_precision,
  output logic signed [4*P-1:0]     sum
);

  localparam int AW     = accw(P);
  localparam int H      = P / 2;
  localparam int LEVELS = (K > 1) ? $clog2(K) : 0;
  localparam int NPOW   = 1 << LEVELS;

  // Elaboration-time guard on the operand precision.
  if ((P % 2) != 0 || P < 4 || P > MAX_P) begin : g_bad_p
    $error("mma_dot_product: P must be even and within [4, MAX_P]");
  end

  logic                   halved_mode;
  logic signed [AW-1:0]   term [NPOW];

  assign halved_mode = (CONFIGURABLE != 0) && halved_precision;

  for (genvar k = 0; k < K; k++) begin : g_term
    logic signed [H-1:0]   a_hi, a_lo, b_hi, b_lo;
    logic signed [P-1:0]   prod_hi, prod_lo;
    logic signed [2*P-1:0] prod_full;

    assign a_hi = H'(hi(MAX_P'(a_row[k]), P));
    assign a_lo = H'(lo(MAX_P'(a_row[k]), P));
    assign b_hi = H'(hi(MAX_P'(b_col[k]), P));
    assign b_lo = H'(lo(MAX_P'(b_col[k]), P));

    // A P/2 x P/2 signed product always fits in P bits, a P x P one in 2P.
    assign prod_hi   = a_hi * b_hi;
    assign prod_lo   = a_lo * b_lo;
    assign prod_full = a_row[k] * b_col[k];

    assign term[k] = halved_mode ? (AW'(prod_hi) + AW'(prod_lo)) : AW'(prod_full);
  end

  // Zero padding so the tree always sees a power-of-two leaf count.
  for (genvar k = K; k < NPOW; k++) begin : g_pad
    assign term[k] = '0;
  end

  function automatic logic signed [AW-1:0] tree_sum(input logic signed [AW-1:0] t [NPOW]);
    logic signed [AW-1:0] v [NPOW];
    v = t;
    for (int w = NPOW / 2; w >= 1; w = w / 2) begin
      for (int i = 0; i < w; i++) begin
        v[i] = v[2*i] + v[2*i+1];
      end
    end
    return v[0];
  endfunction

  if (TREE != 0) begin : g_tree
    assign sum = c_in + tree_sum(term);
  end else begin : g_chain
    logic signed [AW-1:0] acc;

    // NOTE: combinational blocks use blocking '=' so each step sees the previous partial sum;
    //       acc is given a value before the loop so no latch can be inferred.
    always_comb begin
      acc = c_in;
      for (int k = 0; k < NPOW; k++) begin
        acc = acc + term[k];
      end
    end

    assign sum = acc;
  end

endmodule

// File: rtl/matrix_multiply_accumulate.sv
// D = A*B + C over an MxK by KxN tile, optional packed-half mode, one-cycle registered result.
module matrix_multiply_accumulate
  import mma_pkg::*;
#(
  parameter int M            = 2,
  parameter int N            = 2,
  parameter int K            = 2,
  parameter int P            = 8,
  parameter int TREE         = 0,
  parameter int CONFIGURABLE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic signed [P-1:0]   A [M][K],
  input  logic signed [P-1:0]   B [K][N],
  input  logic signed [4*P-1:0] C [M][N],
  input  logic                  halvedPrecision,
  output logic signed [4*P-1:0] D [M][N]
);

  localparam int AW = accw(P);

  logic signed [AW-1:0] sum_w [M][N];
  logic signed [AW-1:0] d_d   [M][N];
  logic signed [AW-1:0] d_q   [M][N];

  for (genvar i = 0; i < M; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic signed [P-1:0] a_row [K];
      logic signed [P-1:0] b_col [K];

      for (genvar k = 0; k < K; k++) begin : g_gather
        assign a_row[k] = A[i][k];
        assign b_col[k] = B[k][j];
      end

      mma_dot_product #(
        .P            (P),
        .K            (K),
        .TREE         (TREE),
        .CONFIGURABLE (CONFIGURABLE)
      ) u_dot (
        .a_row            (a_row),
        .b_col            (b_col),
        .c_in             (C[i][j]),
        .halved_precision (halvedPrecision),
        .sum              (sum_w[i][j])
      );
    end
  end

  always_comb begin
    d_d = sum_w;
  end

  // NOTE: sequential state is updated with non-blocking '<=' so all flops sample together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < M; i++) begin
        for (int j = 0; j < N; j++) begin
          d_q[i][j] <= '0;
        end
      end
    end else begin
      d_q <= d_d;
    end
  end

  assign D = d_q;

endmodule

// File: tb/tb_matrix_multiply_accumulate.sv
// Directed and reference-model checks of matrix_multiply_accumulate (chain, tree and fixed-mode builds).
module tb_matrix_multiply_accumulate;

  logic               clk;
  logic               rst_n;
  logic signed [7:0]  a [2][2];
  logic signed [7:0]  b [2][2];
  logic signed [31:0] c [2][2];
  logic               hp;
  logic signed [31:0] d_chain [2][2];
  logic signed [31:0] d_tree  [2][2];
  logic signed [31:0] d_fixed [2][2];

  int checks = 0;
  int errors = 0;

  matrix_multiply_accumulate #(.M(2), .N(2), .K(2), .P(8), .TREE(0), .CONFIGURABLE(1)) dut_chain (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .C(c), .halvedPrecision(hp), .D(d_chain)
  );

  matrix_multiply_accumulate #(.M(2), .N(2), .K(2), .P(8), .TREE(1), .CONFIGURABLE(1)) dut_tree (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .C(c), .halvedPrecision(hp), .D(d_tree)
  );

  matrix_multiply_accumulate #(.M(2), .N(2), .K(2), .P(8), .TREE(0), .CONFIGURABLE(0)) dut_fixed (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .C(c), .halvedPrecision(hp), .D(d_fixed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Independent reference: plain integer arithmetic on the current inputs.
  function automatic logic [31:0] model(input int i, input int j, input logic halved);
    longint acc;
    logic [7:0] ae, be;
    acc = longint'(c[i][j]);
    for (int k = 0; k < 2; k++) begin
      ae = a[i][k];
      be = b[k][j];
      if (halved)
        acc += longint'($signed(ae[7:4])) * longint'($signed(be[7:4]))
             + longint'($signed(ae[3:0])) * longint'($signed(be[3:0]));
      else
        acc += longint'(a[i][k]) * longint'(b[k][j]);
    end
    return acc[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic signed [7:0] av, input logic signed [7:0] bv,
                         input logic signed [31:0] cv);
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        a[i][j] = av;
        b[i][j] = bv;
        c[i][j] = cv;
      end
    end
  endtask

  task automatic check_all(input string tag, input logic signed [31:0] exp);
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        check($sformatf("%s_chain%0d%0d", tag, i, j), d_chain[i][j], exp);
        check($sformatf("%s_tree%0d%0d", tag, i, j), d_tree[i][j], exp);
      end
    end
  endtask

  initial begin
    // Reset with non-zero operands on the bus.
    rst_n = 1'b0;
    hp    = 1'b0;
    set_all(8'sd3, 8'sd4, 32'sd9);
    step();
    check_all("reset", 32'sd0);
    check("reset_fixed", d_fixed[1][1], 32'sd0);

    // Full-precision product.
    rst_n   = 1'b1;
    a[0][0] = 8'sd1; a[0][1] = 8'sd2; a[1][0] = 8'sd3; a[1][1] = 8'sd4;
    b[0][0] = 8'sd5; b[0][1] = 8'sd6; b[1][0] = 8'sd7; b[1][1] = 8'sd8;
    for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) c[i][j] = 32'sd1;
    step();
    check("full_d00", d_chain[0][0], 32'sd20);
    check("full_d01", d_chain[0][1], 32'sd23);
    check("full_d10", d_chain[1][0], 32'sd44);
    check("full_d11", d_chain[1][1], 32'sd51);
    check("full_tree_d11", d_tree[1][1], 32'sd51);
    check("full_fixed_d10", d_fixed[1][0], 32'sd44);

    // A result sitting in D must be cleared by a later reset.
    rst_n = 1'b0;
    step();
    check_all("reset2", 32'sd0);
    rst_n = 1'b1;

    // Signed extremes.
    set_all(-8'sd128, -8'sd128, 32'sd0);
    step();
    check_all("ext_pos", 32'sd32768);
    set_all(-8'sd128, 8'sd127, -32'sd5);
    step();
    check_all("ext_neg", -32'sd32517);

    // Halved mode: row0 packs {1,-2,3,-4}; everything else packs {1,1}.
    set_all(8'sh11, 8'sh11, 32'sd10);
    a[0][0] = 8'sh1E;
    a[0][1] = 8'sh3C;
    hp      = 1'b1;
    step();
    check("half_d00", d_chain[0][0], 32'sd8);
    check("half_tree_d00", d_tree[0][0], 32'sd8);
    check("half_d10", d_chain[1][0], 32'sd14);
    check("half_tree_d11", d_tree[1][1], 32'sd14);
    // Without halved support the same bits are full-width: 10 + 30*17 + 60*17.
    check("half_fixed_d00", d_fixed[0][0], 32'sd1540);

    // Wrap at 2^32.
    hp = 1'b0;
    set_all(8'sd0, 8'sd0, 32'sd0);
    c[0][0] = 32'h7FFF_FFFF;
    a[0][0] = 8'sd1;
    b[0][0] = 8'sd1;
    step();
    check("wrap_d00", d_chain[0][0], 32'h8000_0000);
    check("wrap_tree_d00", d_tree[0][0], 32'h8000_0000);
    check("wrap_d01", d_chain[0][1], 32'sd0);

    // Back-to-back random cycles with the mode toggling every cycle.
    for (int n = 0; n < 24; n++) begin
      logic [31:0] exp_cfg [2][2];
      logic [31:0] exp_fix [2][2];
      hp = n[0];
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < 2; j++) begin
          a[i][j] = 8'($urandom);
          b[i][j] = 8'($urandom);
          c[i][j] = $urandom;
        end
      end
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < 2; j++) begin
          exp_cfg[i][j] = model(i, j, hp);
          exp_fix[i][j] = model(i, j, 1'b0);
        end
      end
      step();
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < 2; j++) begin
          check($sformatf("rnd%0d_chain%0d%0d", n, i, j), d_chain[i][j], exp_cfg[i][j]);
          check($sformatf("rnd%0d_tree%0d%0d", n, i, j), d_tree[i][j], exp_cfg[i][j]);
          check($sformatf("rnd%0d_fixed%0d%0d", n, i, j), d_fixed[i][j], exp_fix[i][j]);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
